// File: rtl/debug_step_ctrl_pkg.sv
// Shared constants for the debug step controller:
// FSM encoding, host command codes and dump word layout.
package debug_step_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_DUMP,
    ST_PRST
  } state_t;

  localparam logic [7:0] CMD_RUN   = 8'h43;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_PRST  = 8'h52;
  localparam logic [7:0] CMD_DUMP  = 8'h44;
  localparam logic [7:0] CMD_PAUSE = 8'h50;

  localparam int N_WORDS = 15;

  localparam logic [3:0] IDX_ID  = 4'd2;
  localparam logic [3:0] IDX_EX  = 4'd8;
  localparam logic [3:0] IDX_MW  = 4'd12;
  localparam logic [3:0] IDX_CNT = 4'd14;

endpackage

// File: rtl/dump_word_mux.sv
// Selects one 32-bit snapshot word from the pipeline
// latch buses (low word first) or the cycle count.
module dump_word_mux #(
  parameter int LEN = 32
) (
  input  logic [63:0]    if_id,
  input  logic [191:0]   id_ex,
  input  logic [127:0]   ex_mem,
  input  logic [63:0]    mem_wb,
  input  logic [LEN-1:0] cycle_count,
  input  logic [3:0]     idx,
  output logic [LEN-1:0] word
);
  import debug_step_ctrl_pkg::*;

  logic [1:0][31:0] if_w;
  logic [5:0][31:0] id_w;
  logic [3:0][31:0] ex_w;
  logic [1:0][31:0] mw_w;
  logic [2:0]       off_id;
  logic [1:0]       off_ex;
  logic             off_mw;

  assign if_w   = if_id;
  assign id_w   = id_ex;
  assign ex_w   = ex_mem;
  assign mw_w   = mem_wb;
  assign off_id = 3'(idx - IDX_ID);
  assign off_ex = 2'(idx - IDX_EX);
  assign off_mw = 1'(idx - IDX_MW);

  // index range decode onto the owning bus
  always_comb begin
    word = '0;
    unique case (1'b1)
      (idx < IDX_ID):
        word = LEN'(if_w[idx[0]]);
      (idx >= IDX_ID && idx < IDX_EX):
        word = LEN'(id_w[off_id]);
      (idx >= IDX_EX && idx < IDX_MW):
        word = LEN'(ex_w[off_ex]);
      (idx >= IDX_MW && idx < IDX_CNT):
        word = LEN'(mw_w[off_mw]);
      (idx == IDX_CNT):
        word = cycle_count;
      default:
        word = '0;
    endcase
  end

endmodule

// File: rtl/debug_step_ctrl.sv
// Host-driven run/step/pause/dump controller for a
// 5-stage pipeline with cycle counting and halt tracking.
module debug_step_ctrl #(
  parameter int LEN     = 32,
  parameter int NB_CMD  = 8,
  parameter int N_WORDS = debug_step_ctrl_pkg::N_WORDS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  input  logic [NB_CMD-1:0] i_cmd,
  output logic              o_cmd_ready,
  input  logic              i_halt_detected,
  input  logic [63:0]       i_if_id,
  input  logic [191:0]      i_id_ex,
  input  logic [127:0]      i_ex_mem,
  input  logic [63:0]       i_mem_wb,
  output logic              o_pipe_en,
  output logic              o_pipe_rst,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [LEN-1:0]    o_dump_data,
  output logic [3:0]        o_dump_idx,
  output logic [LEN-1:0]    o_cycle_count,
  output logic              o_halted,
  output logic              o_done,
  output logic              o_cmd_err
);
  import debug_step_ctrl_pkg::*;

  localparam logic [NB_CMD-1:0] K_RUN   = NB_CMD'(CMD_RUN);
  localparam logic [NB_CMD-1:0] K_STEP  = NB_CMD'(CMD_STEP);
  localparam logic [NB_CMD-1:0] K_PRST  = NB_CMD'(CMD_PRST);
  localparam logic [NB_CMD-1:0] K_DUMP  = NB_CMD'(CMD_DUMP);
  localparam logic [NB_CMD-1:0] K_PAUSE = NB_CMD'(CMD_PAUSE);
  localparam logic [3:0]        LAST    = 4'(N_WORDS - 1);

  state_t         state;
  state_t         state_nx;
  logic           accept;
  logic           is_run;
  logic           is_step;
  logic           is_prst;
  logic           is_dump;
  logic           is_pause;
  logic           adv;
  logic           last;
  logic           err_nx;
  logic           halt_set;
  logic           done_nx;
  logic [LEN-1:0] word;

  assign o_cmd_ready  = (state == ST_IDLE) ||
                        (state == ST_RUN);
  assign o_dump_valid = (state == ST_DUMP);
  assign accept       = i_cmd_valid & o_cmd_ready;

  assign is_run   = (i_cmd == K_RUN);
  assign is_step  = (i_cmd == K_STEP);
  assign is_prst  = (i_cmd == K_PRST);
  assign is_dump  = (i_cmd == K_DUMP);
  assign is_pause = (i_cmd == K_PAUSE);

  assign adv  = o_dump_valid & i_dump_ready;
  assign last = (o_dump_idx == LAST);

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // next state and one-cycle events
  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    halt_set = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_run: begin
              if (o_halted) err_nx   = 1'b1;
              else          state_nx = ST_RUN;
            end
            is_step: begin
              if (o_halted) err_nx   = 1'b1;
              else          state_nx = ST_STEP;
            end
            is_prst: state_nx = ST_PRST;
            is_dump: state_nx = ST_DUMP;
            default: err_nx   = 1'b1;
          endcase
        end
      end
      ST_RUN: begin
        if (i_halt_detected) begin
          halt_set = 1'b1;
          state_nx = ST_DUMP;
        end else if (accept && is_pause) begin
          state_nx = ST_DUMP;
        end
        if (accept && !is_pause) err_nx = 1'b1;
      end
      ST_STEP: begin
        halt_set = i_halt_detected;
        state_nx = ST_DUMP;
      end
      ST_DUMP: begin
        if (adv && last) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end
      end
      ST_PRST: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // registered controls, cycle counter, halt flag, dump index
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pipe_en     <= 1'b0;
      o_pipe_rst    <= 1'b0;
      o_done        <= 1'b0;
      o_cmd_err     <= 1'b0;
      o_cycle_count <= '0;
      o_halted      <= 1'b0;
      o_dump_idx    <= '0;
    end else begin
      o_pipe_en  <= (state_nx == ST_RUN) ||
                    (state_nx == ST_STEP);
      o_pipe_rst <= (state_nx == ST_PRST);
      o_done     <= done_nx;
      o_cmd_err  <= err_nx;
      if (state == ST_PRST) begin
        o_cycle_count <= '0;
        o_halted      <= 1'b0;
      end else begin
        if (o_pipe_en && o_cycle_count != '1)
          o_cycle_count <= o_cycle_count + LEN'(1);
        if (halt_set) o_halted <= 1'b1;
      end
      if (adv) o_dump_idx <= last ? 4'd0 : o_dump_idx + 4'd1;
    end
  end

  dump_word_mux #(
    .LEN(LEN)
  ) u_mux (
    .if_id      (i_if_id),
    .id_ex      (i_id_ex),
    .ex_mem     (i_ex_mem),
    .mem_wb     (i_mem_wb),
    .cycle_count(o_cycle_count),
    .idx        (o_dump_idx),
    .word       (word)
  );

  assign o_dump_data = o_dump_valid ? word : '0;

endmodule

// File: doc/debug_step_ctrl.md
DEBUG_STEP_CTRL -- requirements
Module: debug_step_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-high, and the ports are named i_clk and i_rst.
REQ-002 Parameters SHALL be:
- LEN, default 32, data word width.
- NB_CMD, default 8, command width.
- N_WORDS, default 15, number of dump words.
REQ-003 Ports SHALL be:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset
- i_cmd_valid  in  1  host command valid
- i_cmd  in  NB_CMD  command code
- o_cmd_ready  out  1  command accepted when valid&ready
- i_halt_detected  in  1  HALT instruction retired in WB
- i_if_id  in  64  IF/ID latch
- i_id_ex  in  192  ID/EX latch
- i_ex_mem  in  128  EX/MEM latch
- i_mem_wb  in  64  MEM/WB latch
- o_pipe_en  out  1  enable for PC and all pipeline latches
- o_pipe_rst  out  1  one-cycle pipeline reset pulse
- o_dump_valid  out  1  dump word valid
- i_dump_ready  in  1  dump word consumed
- o_dump_data  out  LEN  dump word
- o_dump_idx  out  4  dump word index
- o_cycle_count  out  LEN  enabled-cycle count
- o_halted  out  1  program halted flag
- o_done  out  1  one-cycle pulse at dump completion
- o_cmd_err  out  1  one-cycle pulse on a rejected command

Function
REQ-004 The FSM SHALL have the states IDLE, RUN, STEP, DUMP and PRST; the state SHALL be registered.
REQ-005 Commands SHALL be:
- 0x43 'C': run.
- 0x53 'S': step.
- 0x52 'R': pipeline reset.
- 0x44 'D': dump.
- 0x50 'P': pause.
- Any other code: rejected.
REQ-006 o_cmd_ready SHALL be 1 in IDLE and RUN, and 0 in STEP, DUMP and PRST.
REQ-007 In IDLE, an accepted command SHALL move the FSM to its target state on the next cycle: C->RUN, S->STEP, R->PRST, D->DUMP.
- P in IDLE is rejected.
- C or S while o_halted=1 is rejected; the FSM stays in IDLE.
REQ-008 o_pipe_en SHALL be registered and SHALL be 1 exactly while the state is RUN or STEP.
REQ-009 STEP SHALL last exactly one cycle and then go to DUMP.
REQ-010 RUN SHALL go to DUMP on the cycle after either event:
- i_halt_detected=1, which also sets o_halted; or
- an accepted P command.
Any other command accepted in RUN SHALL be discarded and pulse o_cmd_err.
REQ-011 If i_halt_detected=1 and P are accepted in the same cycle, the halt SHALL take precedence; the only effect of P is that it is consumed, with no error.
REQ-012 i_halt_detected SHALL be ignored whenever o_pipe_en=0. When it occurs during STEP, it SHALL set o_halted.
REQ-013 o_cycle_count SHALL increment by 1 on every cycle with o_pipe_en=1 and SHALL saturate at 2^LEN-1, with no wrap.
REQ-014 PRST SHALL last one cycle with o_pipe_rst=1, SHALL clear o_cycle_count and o_halted, and SHALL then return to IDLE.
REQ-015 In DUMP, o_dump_valid SHALL be 1. o_dump_idx SHALL start at 0 and advance on each cycle with valid&ready.
REQ-016 Dump word mapping SHALL be as follows, where word k of a bus is bits [32k+31:32k], low word first:
- idx 0-1: i_if_id.
- idx 2-7: i_id_ex.
- idx 8-11: i_ex_mem.
- idx 12-13: i_mem_wb.
- idx 14: o_cycle_count.
REQ-017 When idx 14 is accepted:
- The FSM SHALL return to IDLE and o_dump_idx SHALL return to 0.
- o_done SHALL pulse for one cycle, on the cycle after acceptance.
REQ-018 o_dump_data and o_dump_idx SHALL remain stable while o_dump_valid=1 and i_dump_ready=0.
REQ-019 Pipeline latches SHALL be frozen during DUMP because o_pipe_en=0 there, so the dumped data is a coherent snapshot.
REQ-020 o_cmd_err SHALL pulse one cycle after a rejected command is accepted.

Reset
REQ-021 While i_rst=1 at a rising edge, the block SHALL be set to:
- state IDLE;
- o_pipe_en=0, o_pipe_rst=0, o_dump_valid=0, o_done=0, o_cmd_err=0;
- o_cycle_count=0, o_halted=0, o_dump_idx=0, o_dump_data=0.
REQ-022 o_cmd_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-023 A reset mid-RUN or mid-DUMP SHALL abort the operation with no o_done pulse.

Structure
REQ-024 A shared package SHALL hold:
- the state encoding;
- the command codes;
- N_WORDS;
- the dump word-index boundaries 2, 8, 12 and 14.
REQ-025 The dump word selection SHALL be a sub-module, dump_word_mux: combinational, driven by the latch buses, the cycle count and the index.
REQ-026 The FSM, the cycle counter and the dump index SHALL reside in debug_step_ctrl.

Verification
REQ-027 Reset then S -> o_pipe_en high for exactly 1 cycle; o_cycle_count=1; 15 dump words with i_dump_ready=1 held high; o_done pulses once.
REQ-028 C, then i_halt_detected after 10 enabled cycles -> o_cycle_count=10 and o_halted=1. A following C -> o_cmd_err pulse and the FSM stays in IDLE.
REQ-029 Dump with i_dump_ready toggling 1/0 -> o_dump_idx sequence is 0..14 with no skips. The words match the mapping: idx 3 = i_id_ex[63:32]; idx 14 = o_cycle_count.
REQ-030 In RUN, P and i_halt_detected in the same cycle -> o_halted=1, no o_cmd_err, DUMP entered. Separately, 0x41 in RUN -> o_cmd_err pulse and RUN continues.
REQ-031 After halt, R -> one o_pipe_rst pulse, o_cycle_count=0, o_halted=0. A following C is accepted.
REQ-032 i_rst asserted at dump idx 5 -> next cycle IDLE with o_dump_valid=0 and no o_done.
